div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_div_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Multi-cycle 32-bit restoring divider for the EX stage.
//               Handles signed (DIV) and unsigned (DIVU) division. One
//               quotient bit is produced per clock, so a divide takes
//               32 steps. A zero divisor takes a short path that returns 0.
//
// Ports       : clk          - single clock, rising edge
//               rst          - asynchronous reset, active low (0 = reset)
//               start_i      - divide request, held high until ready_o
//               annul_i      - flush: abandon the in-flight divide
//               signed_div_i - 1 = DIV (signed), 0 = DIVU (unsigned)
//               opdata1_i    - dividend
//               opdata2_i    - divisor
//               result_o     - {remainder[63:32], quotient[31:0]}, for HI/LO
//               ready_o      - result_o valid this cycle
//               stallreq_o   - pipeline stall request
//
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_BYZERO = 2'd1;
    localparam logic [1:0] c_ST_ON     = 2'd2;
    localparam logic [1:0] c_ST_END    = 2'd3;

    // Counter value during the 32nd (final) division step.
    localparam logic [5:0] c_LAST_STEP = 6'd31;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  state_q,   state_d;
    logic [5:0]  cnt_q,     cnt_d;
    // quo_q starts out holding the dividend magnitude; every step shifts one
    // dividend bit out of the top and one quotient bit in at the bottom.
    logic [31:0] quo_q,     quo_d;
    logic [31:0] rem_q,     rem_d;      // partial remainder
    logic [31:0] dvsr_q,    dvsr_d;     // divisor magnitude
    // Sign fix-ups decided at start time. They already include the
    // signed_div_i qualifier, so a DIVU never applies any negation.
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [63:0] result_q,  result_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_start_ok;
    logic        w_dvsr_zero;
    logic        w_op1_neg;
    logic        w_op2_neg;
    logic [31:0] w_op1_mag;
    logic [31:0] w_op2_mag;
    logic [32:0] w_minuend;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_quo_step;
    logic [31:0] w_rem_step;
    logic [31:0] w_quo_final;
    logic [31:0] w_rem_final;
    logic        w_last_step;
    logic        w_stall;

    assign w_start_ok  = start_i & ~annul_i;
    assign w_dvsr_zero = (opdata2_i == 32'd0);

    // Operand conditioning. Negating 0x80000000 yields 0x80000000 again,
    // which the unsigned datapath then reads correctly as 2^31.
    assign w_op1_neg = signed_div_i & opdata1_i[31];
    assign w_op2_neg = signed_div_i & opdata2_i[31];
    assign w_op1_mag = w_op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_op2_mag = w_op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

    // One restoring step. The decision is a full 33-bit compare of the
    // shifted partial remainder against the divisor. When the compare
    // succeeds the true difference is below the divisor, so it fits in
    // 32 bits and the low-32-bit subtraction is exact.
    assign w_minuend  = {rem_q, quo_q[31]};
    assign w_ge       = (w_minuend >= {1'b0, dvsr_q});
    assign w_diff     = w_minuend[31:0] - dvsr_q;
    assign w_rem_step = w_ge ? w_diff : w_minuend[31:0];
    assign w_quo_step = {quo_q[30:0], w_ge};

    // Final sign restoration, 32-bit wrap-around (0x80000000 / -1 wraps
    // back to 0x80000000 with no overflow indication).
    assign w_quo_final = quo_neg_q ? (~w_quo_step + 32'd1) : w_quo_step;
    assign w_rem_final = rem_neg_q ? (~w_rem_step + 32'd1) : w_rem_step;

    assign w_last_step = (cnt_q == c_LAST_STEP);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_start_ok) begin
                    state_d = w_dvsr_zero ? c_ST_BYZERO : c_ST_ON;
                end
            end
            c_ST_BYZERO: begin
                state_d = annul_i ? c_ST_IDLE : c_ST_END;
            end
            c_ST_ON: begin
                // A flush beats completion, even on the final step.
                if (annul_i) begin
                    state_d = c_ST_IDLE;
                end else if (w_last_step) begin
                    state_d = c_ST_END;
                end
            end
            c_ST_END: begin
                // Hold the result until EX drops its request; annul_i has
                // no effect here because the result is already committed.
                state_d = start_i ? c_ST_END : c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_start_ok && !w_dvsr_zero) begin
                    cnt_d     = 6'd0;
                    quo_d     = w_op1_mag;
                    rem_d     = 32'd0;
                    dvsr_d    = w_op2_mag;
                    quo_neg_d = w_op1_neg ^ w_op2_neg;
                    rem_neg_d = w_op1_neg;
                end
            end
            c_ST_BYZERO: begin
                result_d = 64'h0;
            end
            c_ST_ON: begin
                if (!annul_i) begin
                    cnt_d = cnt_q + 6'd1;
                    quo_d = w_quo_step;
                    rem_d = w_rem_step;
                    if (w_last_step) begin
                        result_d = {w_rem_final, w_quo_final};
                    end
                end
            end
            default: begin
                // END holds everything until the request is released.
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 6'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= 64'h0;
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_stall = 1'b0;
        case (state_q)
            c_ST_IDLE:   w_stall = start_i;
            c_ST_BYZERO: w_stall = 1'b1;
            c_ST_ON:     w_stall = 1'b1;
            default:     w_stall = 1'b0;
        endcase
    end

    always_comb begin
        ready_o    = (state_q == c_ST_END);
        // The result bus is gated so HI/LO sees zero outside END.
        result_o   = ready_o ? result_q : 64'h0;
        // The state register already sits in IDLE during reset, but IDLE
        // passes start_i through; the stall request must be silenced too.
        stallreq_o = rst & w_stall;
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq
// Description : Self-checking bench for div_seq. Vector table plus
//               hand-written flush / reset / END-hold sequences; expected
//               results queue up when a divide is issued and are popped when
//               ready_o is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        start_i      = 1'b0;
    logic        annul_i      = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i    = 32'd0;
    logic [31:0] opdata2_i    = 32'd0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Independent reference: native 64-bit arithmetic, truncating division.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sd, q, r;
        if (b == 32'd0) return 64'h0;
        if (s) begin
            sa = longint'(signed'(a));
            sd = longint'(signed'(b));
        end else begin
            sa = longint'({32'h0, a});
            sd = longint'({32'h0, b});
        end
        q = sa / sd;
        r = sa % sd;
        return {r[31:0], q[31:0]};
    endfunction

    // Entered in cycle 0 (start already driven, #1 after the negedge).
    // Scrambles operands while busy, checks stall/quiet outputs every cycle
    // and the latency, stall drop and scoreboard result at ready_o.
    task automatic wait_ready(input string name, input int exp_lat);
        int          cyc      = 0;
        bit          seen     = 0;
        bit          stall_ok = 1;
        bit          quiet_ok = 1;
        logic [63:0] exp;
        if (stallreq_o !== 1'b1) stall_ok = 0;
        if (ready_o !== 1'b0 || result_o !== 64'h0) quiet_ok = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(1));
            #1;
            if (ready_o === 1'b1) begin
                seen = 1;
            end else begin
                if (stallreq_o !== 1'b1) stall_ok = 0;
                if (result_o !== 64'h0) quiet_ok = 0;
            end
        end
        check({name, " ready_seen"}, 64'(seen), 64'd1);
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " stall_while_busy"}, 64'(stall_ok), 64'd1);
        check({name, " quiet_while_busy"}, 64'(quiet_ok), 64'd1);
        check({name, " stall_in_end"}, 64'(stallreq_o), 64'd0);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check({name, " result"}, result_o, exp);
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input bit s, input logic [63:0] exp);
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        sb_q.push_back(exp);
        #1;
        wait_ready(name, (b == 32'd0) ? 2 : 33);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check({name, " ready_after_end"}, 64'(ready_o), 64'd0);
        check({name, " result_after_end"}, result_o, 64'h0);
    endtask

    initial begin
        bit pulse;

        tbl[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
        tbl[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0};
        tbl[3]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0};
        tbl[4]  = '{32'd5,         32'd0,         1'b0, 32'd0,         32'd0};
        tbl[5]  = '{32'hFFFF_FFF9, 32'd0,         1'b1, 32'd0,         32'd0};
        tbl[6]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1};
        tbl[7]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE};
        tbl[8]  = '{32'hFFFF_FFFF, 32'h10,        1'b0, 32'h0FFF_FFFF, 32'hF};
        tbl[9]  = '{32'h8000_0000, 32'd2,         1'b1, 32'hC000_0000, 32'd0};
        tbl[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000};
        tbl[11] = '{32'd3,         32'd5,         1'b0, 32'd0,         32'd3};

        // Reset: outputs forced low even with start_i asserted.
        start_i = 1'b1;
        #1 rst = 1'b0;
        #12;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'h0);
        check("reset stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle ready", 64'(ready_o), 64'd0);
        check("idle stall", 64'(stallreq_o), 64'd0);

        foreach (tbl[i])
            run_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].r, tbl[i].q});

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            bit          s;
            a = $urandom;
            b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            s = 1'($urandom_range(1));
            run_div($sformatf("rand%0d", i), a, b, s, model(a, b, s));
        end

        // Flush in ON cycle 10, then no ready pulse and a clean 9 / 3.
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 10) begin annul_i = 1'b1; start_i = 1'b0; end
        end
        @(negedge clk);
        #1;
        check("annul_on idle_stall", 64'(stallreq_o), 64'd0);
        check("annul_on ready", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        pulse   = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (ready_o !== 1'b0) pulse = 1;
        end
        check("annul_on no_ready_pulse", 64'(pulse), 64'd0);
        run_div("after_annul 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

        // Flush coinciding with the final step: flush wins.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 32) begin annul_i = 1'b1; start_i = 1'b0; end
        end
        @(negedge clk);
        #1;
        check("annul_last ready", 64'(ready_o), 64'd0);
        check("annul_last result", result_o, 64'h0);
        check("annul_last stall", 64'(stallreq_o), 64'd0);
        annul_i = 1'b0;

        // Flush during BYZERO.
        @(negedge clk);
        opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        #1;
        check("annul_byzero ready", 64'(ready_o), 64'd0);
        check("annul_byzero stall", 64'(stallreq_o), 64'd0);
        annul_i = 1'b0;

        // END holds while start_i stays high; annul_i is ignored there.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        sb_q.push_back({32'd2, 32'd14});
        #1;
        wait_ready("end_hold", 33);
        annul_i = 1'b1;
        @(negedge clk);
        #1;
        check("end_hold ready", 64'(ready_o), 64'd1);
        check("end_hold result", result_o, {32'd2, 32'd14});
        check("end_hold stall", 64'(stallreq_o), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check("end_release ready", 64'(ready_o), 64'd0);

        // Asynchronous reset mid-ON, start_i held through release.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("pre_reset stall", 64'(stallreq_o), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_reset ready", 64'(ready_o), 64'd0);
        check("mid_reset result", result_o, 64'h0);
        check("mid_reset stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb_q.push_back({32'd2, 32'd14});
        #1;
        wait_ready("reset_restart", 33);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check("reset_restart release", 64'(ready_o), 64'd0);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
